// File: rtl/gbif_pkg.sv
// Shared types and opcode decoding for the global-buffer host interface initiator.
package gbif_pkg;

    localparam int DW = 128;
    localparam int CW = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CFG   = 3'd1,
        ST_RD    = 3'd2,
        ST_WR    = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } gbif_state_e;

    localparam logic [2:0] OP_WR0 = 3'd1;
    localparam logic [2:0] OP_WR1 = 3'd2;
    localparam logic [2:0] OP_WEI = 3'd3;

    // Number of 128-bit beats moved by one command.
    function automatic logic [CW-1:0] beat_total(input logic [2:0] op);
        case (op)
            3'd0, OP_WR0, OP_WR1: beat_total = CW'(64);
            OP_WEI:               beat_total = CW'(54);
            default:              beat_total = CW'(512);
        endcase
    endfunction

    // 1 = host drives the bus (read), 0 = ASIC drives the bus (write).
    function automatic logic is_read(input logic [2:0] op);
        is_read = !(op == OP_WR0 || op == OP_WR1);
    endfunction

    function automatic logic [3:0] cfg_info(input logic [2:0] op);
        cfg_info = {op, is_read(op)};
    endfunction

endpackage

// File: rtl/gbif_skid_buf.sv
// Two-entry valid/ready buffer between the host read path and the global buffer.
module gbif_skid_buf
    import gbif_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_val,
    input  logic [DW-1:0] in_data,
    output logic          out_val,
    output logic [DW-1:0] out_data,
    input  logic          out_rdy,
    output logic          space_next
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic [1:0]    count_next;
    logic          push;
    logic          pop;

    assign push     = in_val;
    assign pop      = out_val & out_rdy;
    assign out_val  = (count != 2'd0);
    assign out_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (!push && pop) begin
            count_next = count - 2'd1;
        end
    end

    // Upstream registers its ready from this, so it reflects occupancy after this edge.
    assign space_next = (count_next != 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: rtl/gbif_initiator.sv
// Host-interface initiator: config request, then a fixed-length read or write burst.
module gbif_initiator
    import gbif_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_val,
    input  logic [2:0]    cmd_op,
    output logic          cmd_rdy,
    output logic          cfg_req,
    input  logic          cfg_ack,
    input  logic          host_rd_val,
    output logic          rd_rdy,
    output logic          wr_val,
    input  logic          host_wr_rdy,
    input  logic [DW-1:0] bus_din,
    output logic [DW-1:0] bus_dout,
    output logic          bus_oe,
    output logic          snk_val,
    output logic [DW-1:0] snk_data,
    input  logic          snk_rdy,
    input  logic          src_val,
    input  logic [DW-1:0] src_data,
    output logic          src_rdy,
    output logic          busy,
    output logic          done,
    output gbif_state_e   state,
    output logic [CW-1:0] cnt
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits for ready, and ready may depend on valid.
    gbif_state_e   state_next;
    logic [2:0]    op;
    logic [CW-1:0] n_total;
    logic [CW-1:0] loaded;
    logic [DW-1:0] wr_data;
    logic          cmd_fire;
    logic          rd_fire;
    logic          wr_fire;
    logic          src_fire;
    logic          last_beat;
    logic          space_next;
    logic          flush;

    assign n_total   = beat_total(op);
    assign last_beat = (cnt == n_total - CW'(1));
    assign cmd_fire  = (state == ST_IDLE) & cmd_val;
    assign rd_fire   = (state == ST_RD) & host_rd_val & rd_rdy;
    assign wr_fire   = (state == ST_WR) & wr_val & host_wr_rdy;
    assign src_fire  = src_val & src_rdy;
    assign flush     = (state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (cmd_val) state_next = ST_CFG;
            ST_CFG:   if (cfg_ack) state_next = is_read(op) ? ST_RD : ST_WR;
            ST_RD:    if (rd_fire && last_beat) state_next = ST_DRAIN;
            ST_DRAIN: if (!snk_val) state_next = ST_DONE;
            ST_WR:    if (wr_fire && last_beat) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_rdy  = (state == ST_IDLE);
        cfg_req  = (state == ST_CFG);
        bus_oe   = (state == ST_CFG) || (state == ST_WR);
        busy     = (state != ST_IDLE);
        done     = (state == ST_DONE);
        src_rdy  = (state == ST_WR) && (!wr_val || host_wr_rdy) && (loaded < n_total);
        bus_dout = '0;
        if (state == ST_CFG)     bus_dout = {{(DW-4){1'b0}}, cfg_info(op)};
        else if (state == ST_WR) bus_dout = wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op      <= 3'd0;
            cnt     <= '0;
            loaded  <= '0;
            wr_val  <= 1'b0;
            wr_data <= '0;
            rd_rdy  <= 1'b0;
        end else begin
            if (cmd_fire) op <= cmd_op;

            // cnt holds the index of the beat in flight and parks on the last one.
            if (cmd_fire)                              cnt <= '0;
            else if ((rd_fire || wr_fire) && !last_beat) cnt <= cnt + CW'(1);

            if (cmd_fire)      loaded <= '0;
            else if (src_fire) loaded <= loaded + CW'(1);

            if (cmd_fire) begin
                wr_val  <= 1'b0;
                wr_data <= '0;
            end else if (src_fire) begin
                wr_val  <= 1'b1;
                wr_data <= src_data;
            end else if (wr_fire) begin
                wr_val  <= 1'b0;
            end

            rd_rdy <= (state_next == ST_RD) && space_next;
        end
    end

    gbif_skid_buf u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_val     (rd_fire),
        .in_data    (bus_din),
        .out_val    (snk_val),
        .out_data   (snk_data),
        .out_rdy    (snk_rdy),
        .space_next (space_next)
    );

endmodule

// File: doc/gbif_initiator.md
# gbif_initiator

ASIC-side initiator for the global-buffer host interface. It accepts one transfer command at a time from the on-chip global-buffer controller and issues a config request carrying a 4-bit cfg_info word on the shared 128-bit bus. It then moves a fixed number of 128-bit beats: host→ASIC (read) into an internal sink, or ASIC→host (write) from an internal source. It sits between the pad ring (config_req / switch_rdwr / near_full / OE pins) and the global-buffer datapath.

## Interface
- DW, 128, bus and beat width
- CW, 10, beat-counter width (max 512 beats)
- clk  in  1  core clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_val  in  1  command valid from GB controller
- cmd_op  in  3  opcode: 0,3,4,5,6,7 = read (host drives bus); 1,2 = write (ASIC drives bus)
- cmd_rdy  out  1  command accepted when cmd_val & cmd_rdy
- cfg_req  out  1  config request to host (config_req pin)
- cfg_ack  in  1  host config ready; handshake = cfg_req & cfg_ack
- host_rd_val  in  1  host read-beat valid
- rd_rdy  out  1  ASIC ready for read beat (switch_rdwr pin)
- wr_val  out  1  ASIC write-beat valid (near_full pin)
- host_wr_rdy  in  1  host ready for write beat
- bus_din  in  DW  bus input from pad
- bus_dout  out  DW  bus output to pad
- bus_oe  out  1  1 = ASIC drives bus
- snk_val / snk_data / snk_rdy  out/out/in  1/DW/1  read beats to GB
- src_val / src_data / src_rdy  in/in/out  1/DW/1  write beats from GB
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of transfer

## Operation
- cfg_info = {op[2:0], dir}, with dir = 1 for read opcodes and 0 for opcodes 1 and 2. op is latched on command accept.
- Beat total N: op 0,1,2 → 64; op 3 → 54; op 4–7 → 512. Counter counts 0..N-1; the last beat is the one where cnt == N-1.
- States: IDLE, CFG, RD, WR, DRAIN, DONE.
- IDLE: cmd_rdy=1. On cmd_val: latch op, clear cnt, go to CFG.
- CFG: cfg_req=1, bus_oe=1, bus_dout={124'b0,cfg_info}. On cfg_ack: go to RD if dir=1, else WR.
- RD: bus_oe=0. Beat transferred when host_rd_val & rd_rdy; bus_din is pushed into a 2-entry skid buffer that drives snk_*. rd_rdy is registered and equals (state==RD) & buffer has ≥1 free entry after this cycle's push/pop. The last beat goes to DRAIN.
- DRAIN: rd_rdy=0. When the buffer is empty, go to DONE.
- WR: bus_oe=1. A wr_val/bus_dout holding register loads src_data when src_val & src_rdy. src_rdy = (state==WR) & (!wr_val | host_wr_rdy) & (beats loaded < N). A beat completes on wr_val & host_wr_rdy. The last completion goes to DONE.
- DONE: done=1 for one cycle, then IDLE. cmd_rdy=0, so a new command is not accepted in DONE.
- Any unexpected host handshake (host_rd_val outside RD, or cfg_ack outside CFG) is ignored.

## Timing
- Reset values: cmd_rdy=1 (IDLE), cfg_req=0, rd_rdy=0, wr_val=0, bus_oe=0, bus_dout=0, snk_val=0, src_rdy=0, busy=0, done=0.
- Reset mid-transfer: immediately returns to IDLE, flushes the skid buffer, clears cnt and the holding register. No done pulse.
- Command accept → cfg_req high on the next cycle. cfg_req stays high until cfg_ack; it must be low in the cycle after the handshake.
- Read: bus_din sampled on the handshake edge. Latency to snk_val is 1 cycle. Throughput is 1 beat/cycle while snk_rdy=1.
- Write: src handshake → wr_val on the next cycle. wr_val/bus_dout are held stable while !host_wr_rdy. Throughput is 1 beat/cycle.
- bus_oe switches only on state transitions, so there is no same-cycle turnaround. bus_oe falls on entry to RD.
- Counter wrap: cnt never exceeds N-1 and resets on command accept. For N=512, cnt reaches 511 without overflowing CW=10.

## Structure
- gbif_pkg holds:
  - the state enum;
  - opcode constants OP_WR0=1, OP_WR1=2, OP_WEI=3;
  - the beat-total function op→N;
  - the dir function.
- Sub-module gbif_skid_buf: 2-entry valid/ready buffer, DW wide, with a synchronous flush input.

## Test plan
- op=0, cfg_ack after 3 cycles, host streams 64 beats (data = beat index), snk_rdy=1 → bus_dout=0x1 in CFG, 64 snk beats in order 0..63, done pulses once, cmd_rdy returns to 1.
- op=1, host_wr_rdy toggling 50%, src supplies 0..63 → 64 wr beats in order, bus_dout stable while stalled, bus_oe=1 throughout WR.
- op=3 with snk_rdy low for 10 cycles mid-stream → rd_rdy drops within 1 cycle of the buffer filling, no beat is lost or duplicated, exactly 54 beats, DRAIN is entered, done pulses.
- op=4 → 512 beats counted, cnt peaks at 511, done asserted only after the final snk handshake.
- rst_n asserted during beat 20 of op=2 → all outputs return to reset values asynchronously. A fresh op=0 command then completes normally.
- cmd_val held high through DONE → second command accepted only in IDLE; host_rd_val pulses in IDLE and CFG are ignored.
